uart_tx_driver: RTL

UART transmitter that pairs with the team's existing UART receiver driver, for the car controller's serial link (telemetry and command echo). It serialises one byte per frame (start bit, 8 data bits LSB first, stop bit) on `tx` and takes bytes through a valid/ready handshake. The baud rate defaults to a parameter value and can be changed at runtime with the same set_baudrate/baudrate scheme the receiver uses, so both directions can be retuned together.

---
 rtl/uart_tx_driver.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_driver.sv
// UART transmitter, 8 data bits LSB first, one stop bit, valid/ready byte input, runtime baud retune.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) before the stop bit.

module uart_tx_driver #(
  parameter int unsigned CLK_FREQ_HZ  = 125000000,
  parameter int unsigned DEFAULT_BAUD = 115200,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_tx,
  input  logic        set_baudrate,
  input  logic [30:0] baudrate,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done
);

  // state    | meaning
  // S_IDLE   | line high, tx_ready follows en_tx, waiting for a byte
  // S_START  | start bit (low) for one bit time
  // S_DATA   | eight data bits, LSB first
  // S_PARITY | parity bit (only with UART_TX_PARITY_EN)
  // S_STOP   | stop bit (high); tx_done pulses on the way back to S_IDLE

  localparam logic [30:0] CLK_FREQ_W  = 31'(CLK_FREQ_HZ);
  localparam logic [30:0] DIV_DEFAULT = 31'(CLK_FREQ_HZ / DEFAULT_BAUD);

  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_driver: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  logic        set_baud_q;
  logic [30:0] baud_q;
  logic [1:0]  set_sr_q;
  logic [30:0] div_q;
  logic [30:0] cand_d;

  state_e      state_q;
  logic [30:0] frame_div_q;
  logic [30:0] cnt_q;
  logic [30:0] cnt_d;
  logic        bit_end;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  // A zero baudrate yields candidate 0, which the >=2 test then rejects.
  always_comb begin
    cand_d = '0;
    if (baud_q != '0) begin
      cand_d = CLK_FREQ_W / baud_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      set_baud_q <= 1'b0;
      baud_q     <= '0;
      set_sr_q   <= 2'b00;
      div_q      <= DIV_DEFAULT;
    end else begin
      set_baud_q <= set_baudrate;
      baud_q     <= baudrate;
      set_sr_q   <= {set_sr_q[0], set_baud_q};
      if (set_sr_q == 2'b01 && cand_d >= 31'd2) begin
        div_q <= cand_d;
      end
    end
  end

  assign bit_end = (cnt_q == frame_div_q - 31'd1);

  always_comb begin
    cnt_d = cnt_q + 31'd1;
    if (bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      frame_div_q <= DIV_DEFAULT;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (tx_valid && ready_q) begin
            shift_q     <= tx_data;
            frame_div_q <= div_q;
`ifdef UART_TX_PARITY_EN
            par_q       <= (^tx_data) ^ PARITY_ODD[0];
`endif
            state_q     <= S_START;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
          end else begin
            ready_q <= en_tx;
          end
        end
        S_START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= S_DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end
        S_DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= en_tx;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
